// File: rtl/mmss_stopwatch_pkg.sv
// Shared digit types, 7-segment patterns and BCD step/clamp helpers for the MM:SS stopwatch.
// Pure combinational helpers; no latency, no flow control.
package stopwatch_pkg;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t m_t;
        bcd_t m_u;
        bcd_t s_t;
        bcd_t s_u;
    } digits_t;

    localparam bcd_t    TENS_MAX   = 4'd5;
    localparam bcd_t    UNITS_MAX  = 4'd9;
    localparam digits_t DIGITS_MAX = {TENS_MAX, UNITS_MAX, TENS_MAX, UNITS_MAX};

    // {a,b,c,d,e,f,g}, segment lit = 0
    localparam logic [6:0] SEG_0   = 7'b0000001;
    localparam logic [6:0] SEG_1   = 7'b1001111;
    localparam logic [6:0] SEG_2   = 7'b0010010;
    localparam logic [6:0] SEG_3   = 7'b0000110;
    localparam logic [6:0] SEG_4   = 7'b1001100;
    localparam logic [6:0] SEG_5   = 7'b0100100;
    localparam logic [6:0] SEG_6   = 7'b0100000;
    localparam logic [6:0] SEG_7   = 7'b0001111;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0000100;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    function automatic logic [6:0] seg_decode(bcd_t d, logic active_low);
        logic [6:0] pat;
        case (d)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_OFF;
        endcase
        return active_low ? pat : ~pat;
    endfunction

    function automatic bcd_t clamp_digit(bcd_t d, bcd_t max);
        return (d > max) ? max : d;
    endfunction

    function automatic logic digit_at_limit(bcd_t v, bcd_t max, logic down);
        return down ? (v == 4'd0) : (v >= max);
    endfunction

    function automatic bcd_t digit_next(bcd_t v, bcd_t max, logic down);
        if (down)
            return (v == 4'd0) ? max : v - 4'd1;
        return (v >= max) ? 4'd0 : v + 4'd1;
    endfunction

    // One count step up or down; each digit rolls only when all lower digits roll.
    function automatic digits_t digits_step(digits_t d, logic down);
        digits_t n;
        logic    c0;
        logic    c1;
        logic    c2;
        c0    = digit_at_limit(d.s_u, UNITS_MAX, down);
        c1    = c0 && digit_at_limit(d.s_t, TENS_MAX, down);
        c2    = c1 && digit_at_limit(d.m_u, UNITS_MAX, down);
        n.s_u = digit_next(d.s_u, UNITS_MAX, down);
        n.s_t = c0 ? digit_next(d.s_t, TENS_MAX, down) : d.s_t;
        n.m_u = c1 ? digit_next(d.m_u, UNITS_MAX, down) : d.m_u;
        n.m_t = c2 ? digit_next(d.m_t, TENS_MAX, down) : d.m_t;
        return n;
    endfunction

endpackage

// File: rtl/mmss_stopwatch_if.sv
// Button inputs and display/status outputs of the stopwatch; COUNTDOWN_EN adds preset/mode/done.
// Plain wires; no latency, no backpressure.
interface mmss_stopwatch_if;
    logic       btn_run;
    logic       btn_lap;
    logic [6:0] hex0;
    logic [6:0] hex1;
    logic [6:0] hex2;
    logic [6:0] hex3;
    logic       running;
    logic       sec_tick;
    logic       wrap;
`ifdef COUNTDOWN_EN
    logic       mode_down;
    logic       load;
    logic [7:0] preset_m;
    logic [7:0] preset_s;
    logic       done;

    modport master (
        output btn_run, btn_lap, mode_down, load, preset_m, preset_s,
        input  hex0, hex1, hex2, hex3, running, sec_tick, wrap, done
    );
    modport slave (
        input  btn_run, btn_lap, mode_down, load, preset_m, preset_s,
        output hex0, hex1, hex2, hex3, running, sec_tick, wrap, done
    );
`else
    modport master (
        output btn_run, btn_lap,
        input  hex0, hex1, hex2, hex3, running, sec_tick, wrap
    );
    modport slave (
        input  btn_run, btn_lap,
        output hex0, hex1, hex2, hex3, running, sec_tick, wrap
    );
`endif
endinterface

// File: rtl/mmss_stopwatch_debounce.sv
// Button conditioner: 2-FF synchroniser, stable-level filter, single-cycle press pulse on accepted rise.
// Latency: press pulse DEBOUNCE_CYCLES+2 cycles after the raw edge; no backpressure.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic press
);
    localparam int            CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          armed;
    logic [CW-1:0] cnt;

    // Synchroniser keeps sampling through reset so a held button is seen as held.
    always_ff @(posedge clock) begin
        sync1 <= btn;
        sync2 <= sync1;
    end

    // armed stays low after reset until the button is seen released, so a held key is not re-accepted.
    always_ff @(posedge clock) begin
        if (reset) begin
            level <= 1'b0;
            armed <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (!sync2)
                armed <= 1'b1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync2;
                press <= sync2 && armed;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/mmss_stopwatch.sv
// MM:SS stopwatch with run/pause and lap hold driving four 7-seg digits; COUNTDOWN_EN adds preset load and count-down.
// Latency: sec_tick/wrap/done one cycle after the step; hex outputs combinational from the shown digits; no backpressure.
module mmss_stopwatch #(
    parameter int CLK_HZ          = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int SEG_ACTIVE_LOW  = 1
) (
    input  logic              clock,
    input  logic              reset,
    mmss_stopwatch_if.slave   sw
);
    import stopwatch_pkg::*;

    localparam int            PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic          ACT_LOW    = (SEG_ACTIVE_LOW != 0);

    logic [PW-1:0] presc;
    digits_t       cur;
    digits_t       disp;
    digits_t       nxt;
    digits_t       shown;
    logic          running_q;
    logic          lap;
    logic          sec_tick_q;
    logic          wrap_q;
    logic          run_press;
    logic          lap_press;
    logic          step;
    logic          down;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run (
        .clock (clock),
        .reset (reset),
        .btn   (sw.btn_run),
        .press (run_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lap (
        .clock (clock),
        .reset (reset),
        .btn   (sw.btn_lap),
        .press (lap_press)
    );

`ifdef COUNTDOWN_EN
    logic done_q;
    assign down    = sw.mode_down;
    assign sw.done = done_q;
`else
    assign down = 1'b0;
`endif

    // Step decision uses the current running value, so a same-cycle run press toggles afterwards.
    assign step = running_q && (presc == PRESC_LAST);
    assign nxt  = digits_step(cur, down);

    always_ff @(posedge clock) begin
        if (reset) begin
            presc      <= '0;
            cur        <= '0;
            disp       <= '0;
            running_q  <= 1'b0;
            lap        <= 1'b0;
            sec_tick_q <= 1'b0;
            wrap_q     <= 1'b0;
`ifdef COUNTDOWN_EN
            done_q     <= 1'b0;
`endif
        end else begin
            sec_tick_q <= step;
            wrap_q     <= step && !down && (cur == DIGITS_MAX);
            if (running_q)
                presc <= step ? '0 : presc + 1'b1;
            if (lap_press) begin
                lap <= !lap;
                if (!lap)
                    disp <= cur;
            end
`ifdef COUNTDOWN_EN
            done_q <= step && down && (nxt == '0);
            if (step)
                cur <= nxt;
            else if (sw.load && !running_q)
                cur <= {clamp_digit(sw.preset_m[7:4], TENS_MAX), clamp_digit(sw.preset_m[3:0], UNITS_MAX),
                        clamp_digit(sw.preset_s[7:4], TENS_MAX), clamp_digit(sw.preset_s[3:0], UNITS_MAX)};
            if (step && down && (nxt == '0))
                running_q <= 1'b0;
            else if (run_press && !(down && (cur == '0)))
                running_q <= !running_q;
`else
            if (step)
                cur <= nxt;
            if (run_press)
                running_q <= !running_q;
`endif
        end
    end

    assign shown       = lap ? disp : cur;
    assign sw.hex0     = seg_decode(shown.s_u, ACT_LOW);
    assign sw.hex1     = seg_decode(shown.s_t, ACT_LOW);
    assign sw.hex2     = seg_decode(shown.m_u, ACT_LOW);
    assign sw.hex3     = seg_decode(shown.m_t, ACT_LOW);
    assign sw.running  = running_q;
    assign sw.sec_tick = sec_tick_q;
    assign sw.wrap     = wrap_q;
endmodule

// File: tb/tb_mmss_stopwatch.sv
// Directed bench for mmss_stopwatch with CLK_HZ=10, DEBOUNCE_CYCLES=4; countdown section built only with COUNTDOWN_EN.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_mmss_stopwatch;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    logic [6:0] seg_lut [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    always #5 clock = ~clock;

    mmss_stopwatch_if sw();

    mmss_stopwatch #(
        .CLK_HZ          (10),
        .DEBOUNCE_CYCLES (4),
        .SEG_ACTIVE_LOW  (1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .sw    (sw)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_time(input string tag, input int mt, input int mu, input int st, input int su);
        check({tag, ".hex3"}, sw.hex3, seg_lut[mt]);
        check({tag, ".hex2"}, sw.hex2, seg_lut[mu]);
        check({tag, ".hex1"}, sw.hex1, seg_lut[st]);
        check({tag, ".hex0"}, sw.hex0, seg_lut[su]);
    endtask

    initial begin
        sw.btn_run = 1'b0;
        sw.btn_lap = 1'b0;
`ifdef COUNTDOWN_EN
        sw.mode_down = 1'b0;
        sw.load      = 1'b0;
        sw.preset_m  = 8'h00;
        sw.preset_s  = 8'h00;
`endif
        // reset state
        cyc(3);
        check_time("reset", 0, 0, 0, 0);
        check1("reset_running", sw.running, 1'b0);
        check1("reset_tick", sw.sec_tick, 1'b0);
        check1("reset_wrap", sw.wrap, 1'b0);
        reset = 1'b0;

        // start: running rises 7 edges after the press
        sw.btn_run = 1'b1;
        cyc(6); check1("run_not_yet", sw.running, 1'b0);
        cyc(1); check1("run_on", sw.running, 1'b1);
        cyc(1); sw.btn_run = 1'b0;
        cyc(8); check1("tick_not_yet", sw.sec_tick, 1'b0);
        check_time("pre_tick", 0, 0, 0, 0);
        cyc(1); check1("tick_first", sw.sec_tick, 1'b1);
        check("hex0_one", sw.hex0, 7'b1001111);
        cyc(1); check1("tick_one_cycle", sw.sec_tick, 1'b0);

        // pause with prescaler at 8, hold, resume: step two cycles after resuming
        sw.btn_run = 1'b1;
        cyc(7); check1("paused", sw.running, 1'b0);
        cyc(1); sw.btn_run = 1'b0;
        cyc(25); check_time("frozen", 0, 0, 0, 1);
        check1("frozen_tick", sw.sec_tick, 1'b0);
        sw.btn_run = 1'b1;
        cyc(7); check1("resumed", sw.running, 1'b1);
        cyc(1); sw.btn_run = 1'b0;
        check1("fraction_kept_a", sw.sec_tick, 1'b0);
        cyc(1); check1("fraction_kept_b", sw.sec_tick, 1'b1);
        check_time("after_resume", 0, 0, 0, 2);

        // 00:02 + 3597 steps = 59:59, then wrap
        cyc(35970); check_time("full", 5, 9, 5, 9);
        check1("full_no_wrap", sw.wrap, 1'b0);
        cyc(9); check1("wrap_not_yet", sw.wrap, 1'b0);
        cyc(1); check1("wrap_pulse", sw.wrap, 1'b1);
        check_time("wrapped", 0, 0, 0, 0);
        cyc(1); check1("wrap_one_cycle", sw.wrap, 1'b0);

        // short glitches leave running alone
        sw.btn_run = 1'b1; cyc(2); sw.btn_run = 1'b0;
        cyc(4);
        check1("glitch2", sw.running, 1'b1);
        sw.btn_run = 1'b1; cyc(3); sw.btn_run = 1'b0;
        cyc(8);
        check1("glitch3", sw.running, 1'b1);
        check_time("after_glitch", 0, 0, 0, 1);

        // lap hold at 00:05 while counting reaches 00:08
        cyc(30);
        sw.btn_lap = 1'b1;
        cyc(7); check_time("lap_latch", 0, 0, 0, 5);
        cyc(1); sw.btn_lap = 1'b0;
        cyc(25); check_time("lap_frozen", 0, 0, 0, 5);
        sw.btn_lap = 1'b1;
        cyc(6); check("lap_still_held", sw.hex0, 7'b0100100);
        cyc(1); check_time("lap_release", 0, 0, 0, 8);
        sw.btn_lap = 1'b0;

        // reset while button held: not accepted until released and pressed again
        sw.btn_run = 1'b1;
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        check_time("mid_reset", 0, 0, 0, 0);
        check1("mid_reset_running", sw.running, 1'b0);
        cyc(10); check1("held_not_accepted", sw.running, 1'b0);
        sw.btn_run = 1'b0;
        cyc(8);
        sw.btn_run = 1'b1;
        cyc(7); check1("repress_accepted", sw.running, 1'b1);
        sw.btn_run = 1'b0;

`ifdef COUNTDOWN_EN
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        sw.mode_down = 1'b1;
        sw.preset_m  = 8'h01;
        sw.preset_s  = 8'h00;
        sw.load      = 1'b1;
        cyc(1); sw.load = 1'b0;
        check_time("cd_load", 0, 1, 0, 0);
        sw.btn_run = 1'b1;
        cyc(7); check1("cd_run", sw.running, 1'b1);
        cyc(1); sw.btn_run = 1'b0;
        cyc(9); check_time("cd_first", 0, 0, 5, 9);
        cyc(580); check_time("cd_one", 0, 0, 0, 1);
        check1("cd_done_idle", sw.done, 1'b0);
        cyc(9); check1("cd_done_not_yet", sw.done, 1'b0);
        cyc(1); check1("cd_done", sw.done, 1'b1);
        check1("cd_stopped", sw.running, 1'b0);
        check_time("cd_zero", 0, 0, 0, 0);
        cyc(1); check1("cd_done_one_cycle", sw.done, 1'b0);
        sw.btn_run = 1'b1;
        cyc(8); check1("cd_run_at_zero", sw.running, 1'b0);
        sw.btn_run = 1'b0;
        sw.preset_m = 8'h00;
        sw.preset_s = 8'h7A;
        sw.load     = 1'b1;
        cyc(1); sw.load = 1'b0;
        check_time("cd_clamp", 0, 0, 5, 9);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
